run_ctrl: RTL and testbench

Run controller that sequences the single-cycle RISC-V core: it decides, cycle by cycle, whether the core may commit an instruction. It gates PC update, register-file write and data-memory write through one enable. It supports free-run, single-step, external halt, a PC breakpoint and self-loop halt detection. It sits beside the core, reads the current `pc` and `instr`, and drives `pc_en` into `top_pc` and the write-enable gating.

---
 rtl/run_ctrl_pkg.sv | 22 ++
 rtl/run_ctrl_edge_sync.sv | 28 ++
 rtl/run_ctrl.sv | 147 ++++++++++++++
 tb/tb_run_ctrl.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/run_ctrl_pkg.sv
// Shared types and constants for the core run controller.
// Holds FSM states, halt causes and the self-loop instruction word.
package run_ctrl_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      STEP = 2'd2,
      HALT = 2'd3
   } run_state_t;

   typedef enum logic [1:0] {
      CAUSE_NONE = 2'd0,
      CAUSE_EXT  = 2'd1,
      CAUSE_BP   = 2'd2,
      CAUSE_LOOP = 2'd3
   } halt_cause_t;

   // jal x0,0 : the core spins on itself
   localparam logic [31:0] HALT_INSTR = 32'h0000_006F;

endpackage

// File: rtl/run_ctrl_edge_sync.sv
// Two-flop synchronizer with a rising-edge detector for a button level.
// rise is high for one cycle per low-to-high transition.
module edge_sync (
   input  logic clk,
   input  logic rst,
   input  logic din,
   output logic rise
);

   logic s1;
   logic s2;
   logic prev;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1   <= 1'b0;
         s2   <= 1'b0;
         prev <= 1'b0;
      end else begin
         s1   <= din;
         s2   <= s1;
         prev <= s2;
      end
   end

   assign rise = s2 & ~prev;

endmodule

// File: rtl/run_ctrl.sv
// Run controller for the single-cycle core: one commit enable gates
// PC update and all writes; supports run, step, halt, breakpoint.
module run_ctrl
   import run_ctrl_pkg::*;
#(
   parameter int ADDRESS_WIDTH = 32,
   parameter int DATA_WIDTH    = 32,
   parameter int CNT_WIDTH     = 32
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     trigger,
   input  logic                     step_req,
   input  logic                     halt_req,
   input  logic                     bp_en,
   input  logic [ADDRESS_WIDTH-1:0] bp_addr,
   input  logic [ADDRESS_WIDTH-1:0] pc,
   input  logic [DATA_WIDTH-1:0]    instr,
   output logic                     pc_en,
   output logic                     running,
   output logic                     halted,
   output logic [1:0]               halt_cause,
   output logic [CNT_WIDTH-1:0]     cycle_count
);

   localparam logic [DATA_WIDTH-1:0] HALT_WORD = DATA_WIDTH'(HALT_INSTR);

   run_state_t  state_q, state_d;
   halt_cause_t cause_q, cause_d;
   logic        skip_q, skip_d;
   logic        running_q;
   logic        halted_q;
   logic [CNT_WIDTH-1:0] cnt_q;

   logic trig_rise;
   logic step_rise;
   logic bp_hit;
   logic loop_hit;
   logic halt_now;

   edge_sync u_trig_sync (
      .clk  (clk),
      .rst  (rst),
      .din  (trigger),
      .rise (trig_rise)
   );

   edge_sync u_step_sync (
      .clk  (clk),
      .rst  (rst),
      .din  (step_req),
      .rise (step_rise)
   );

   // skip_bp lets a resume from a breakpoint commit that instruction once
   assign bp_hit   = bp_en & (pc == bp_addr) & ~skip_q;
   assign loop_hit = (instr == HALT_WORD);
   assign halt_now = halt_req | bp_hit | loop_hit;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         cause_q   <= CAUSE_NONE;
         skip_q    <= 1'b0;
         running_q <= 1'b0;
         halted_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         cause_q   <= cause_d;
         skip_q    <= skip_d;
         running_q <= (state_d == RUN);
         halted_q  <= (state_d == HALT);
      end
   end

   always_comb begin
      state_d = state_q;
      cause_d = cause_q;
      skip_d  = skip_q;
      unique case (state_q)
         IDLE: begin
            if (trig_rise) begin
               state_d = RUN;
            end else if (step_rise) begin
               state_d = STEP;
            end
         end
         RUN: begin
            skip_d = 1'b0;
            if (halt_now) begin
               state_d = HALT;
               if (halt_req) begin
                  cause_d = CAUSE_EXT;
               end else if (bp_hit) begin
                  cause_d = CAUSE_BP;
               end else begin
                  cause_d = CAUSE_LOOP;
               end
            end
         end
         STEP: begin
            if (halt_req) begin
               state_d = HALT;
               cause_d = CAUSE_EXT;
            end else begin
               state_d = IDLE;
            end
         end
         HALT: begin
            if (trig_rise && !halt_req) begin
               state_d = RUN;
               cause_d = CAUSE_NONE;
               skip_d  = 1'b1;
            end else if (step_rise) begin
               state_d = STEP;
               cause_d = CAUSE_NONE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_comb begin
      pc_en = 1'b0;
      unique case (state_q)
         RUN:     pc_en = ~halt_now;
         STEP:    pc_en = ~halt_req;
         default: pc_en = 1'b0;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
      end else if (pc_en && (cnt_q != '1)) begin
         cnt_q <= cnt_q + 1'b1;
      end
   end

   assign running     = running_q;
   assign halted      = halted_q;
   assign halt_cause  = cause_q;
   assign cycle_count = cnt_q;

endmodule

// File: tb/tb_run_ctrl.sv
// Directed self-checking bench for run_ctrl with a tiny core PC model.
// Counter width is 4 so saturation is reachable quickly.
module tb_run_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        trigger;
   logic        step_req;
   logic        halt_req;
   logic        bp_en;
   logic [31:0] bp_addr;
   logic [31:0] pc;
   logic [31:0] instr;
   logic        pc_en;
   logic        running;
   logic        halted;
   logic [1:0]  halt_cause;
   logic [3:0]  cycle_count;

   logic        core_rst;
   logic [31:0] loop_pc;

   int n_chk = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   run_ctrl #(
      .ADDRESS_WIDTH (32),
      .DATA_WIDTH    (32),
      .CNT_WIDTH     (4)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .trigger     (trigger),
      .step_req    (step_req),
      .halt_req    (halt_req),
      .bp_en       (bp_en),
      .bp_addr     (bp_addr),
      .pc          (pc),
      .instr       (instr),
      .pc_en       (pc_en),
      .running     (running),
      .halted      (halted),
      .halt_cause  (halt_cause),
      .cycle_count (cycle_count)
   );

   // core model: PC steps by 4, wraps after 0x1C
   always @(posedge clk) begin
      if (core_rst) begin
         pc <= 32'h0;
      end else if (pc_en) begin
         pc <= (pc == 32'h1C) ? 32'h0 : pc + 32'd4;
      end
   end

   assign instr = (pc == loop_pc) ? 32'h0000_006F : 32'h0000_0013;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h", tag, got, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic press(input bit stp);
      if (stp) step_req = 1'b1;
      else     trigger  = 1'b1;
      @(negedge clk);
      trigger  = 1'b0;
      step_req = 1'b0;
   endtask

   task automatic do_reset();
      rst      = 1'b1;
      core_rst = 1'b1;
      @(negedge clk);
      rst      = 1'b0;
      core_rst = 1'b0;
   endtask

   initial begin
      rst      = 1'b1;
      core_rst = 1'b1;
      trigger  = 1'b0;
      step_req = 1'b0;
      halt_req = 1'b0;
      bp_en    = 1'b0;
      bp_addr  = 32'h0;
      loop_pc  = 32'hFFF;
      cyc(2);
      chk("rst_pc_en", 32'(pc_en), 32'd0);
      chk("rst_running", 32'(running), 32'd0);
      chk("rst_halted", 32'(halted), 32'd0);
      chk("rst_cause", 32'(halt_cause), 32'd0);
      chk("rst_cnt", 32'(cycle_count), 32'd0);
      rst      = 1'b0;
      core_rst = 1'b0;
      cyc(1);
      chk("idle_pc_en", 32'(pc_en), 32'd0);

      // held trigger: RUN after E2, first commit at E3, no retrigger
      trigger = 1'b1;
      cyc(1);
      chk("lat_e0", 32'(pc_en), 32'd0);
      cyc(1);
      chk("lat_e1", 32'(pc_en), 32'd0);
      cyc(1);
      chk("lat_e2", 32'(pc_en), 32'd1);
      chk("lat_run", 32'(running), 32'd1);
      chk("lat_cnt0", 32'(cycle_count), 32'd0);
      cyc(1);
      chk("cnt1", 32'(cycle_count), 32'd1);
      cyc(1);
      chk("cnt2", 32'(cycle_count), 32'd2);
      trigger = 1'b0;
      cyc(1);
      chk("cnt3", 32'(cycle_count), 32'd3);
      chk("still_run", 32'(pc_en), 32'd1);

      // asynchronous reset mid-run
      rst      = 1'b1;
      core_rst = 1'b1;
      #1;
      chk("arst_pc_en", 32'(pc_en), 32'd0);
      chk("arst_running", 32'(running), 32'd0);
      chk("arst_cnt", 32'(cycle_count), 32'd0);
      @(negedge clk);
      rst      = 1'b0;
      core_rst = 1'b0;

      // breakpoint at 0x10
      bp_en   = 1'b1;
      bp_addr = 32'h10;
      press(1'b0);
      cyc(2);
      chk("bp_run", 32'(pc_en), 32'd1);
      cyc(4);
      chk("bp_pc", pc, 32'h10);
      chk("bp_pc_en", 32'(pc_en), 32'd0);
      chk("bp_cnt", 32'(cycle_count), 32'd4);
      cyc(1);
      chk("bp_halted", 32'(halted), 32'd1);
      chk("bp_cause", 32'(halt_cause), 32'd2);
      chk("bp_not_run", 32'(running), 32'd0);

      // resume: 0x10 commits once, breakpoint hits on the next lap
      press(1'b0);
      cyc(2);
      chk("res_pc_en", 32'(pc_en), 32'd1);
      chk("res_cause", 32'(halt_cause), 32'd0);
      chk("res_running", 32'(running), 32'd1);
      cyc(1);
      chk("res_cnt", 32'(cycle_count), 32'd5);
      chk("res_pc", pc, 32'h14);
      cyc(7);
      chk("lap_pc", pc, 32'h10);
      chk("lap_pc_en", 32'(pc_en), 32'd0);
      chk("lap_cnt", 32'(cycle_count), 32'd12);
      cyc(1);
      chk("lap_halted", 32'(halted), 32'd1);
      chk("lap_cause", 32'(halt_cause), 32'd2);

      // trigger while halt_req held is ignored
      halt_req = 1'b1;
      press(1'b0);
      cyc(3);
      chk("hreq_stay", 32'(halted), 32'd1);
      chk("hreq_no_run", 32'(running), 32'd0);
      halt_req = 1'b0;

      // external halt and breakpoint together: external wins
      do_reset();
      press(1'b0);
      cyc(6);
      halt_req = 1'b1;
      chk("both_pc", pc, 32'h10);
      chk("both_pc_en", 32'(pc_en), 32'd0);
      cyc(1);
      chk("both_halted", 32'(halted), 32'd1);
      chk("both_cause", 32'(halt_cause), 32'd1);
      halt_req = 1'b0;

      // self-loop at 0x8
      do_reset();
      bp_en   = 1'b0;
      loop_pc = 32'h8;
      press(1'b0);
      cyc(4);
      chk("loop_pc_en", 32'(pc_en), 32'd0);
      chk("loop_cnt", 32'(cycle_count), 32'd2);
      cyc(1);
      chk("loop_halted", 32'(halted), 32'd1);
      chk("loop_cause", 32'(halt_cause), 32'd3);

      // two single steps
      do_reset();
      loop_pc = 32'hFFF;
      press(1'b1);
      cyc(2);
      chk("step_pc_en", 32'(pc_en), 32'd1);
      chk("step_not_run", 32'(running), 32'd0);
      cyc(1);
      chk("step1_cnt", 32'(cycle_count), 32'd1);
      chk("step1_off", 32'(pc_en), 32'd0);
      press(1'b1);
      cyc(3);
      chk("step2_cnt", 32'(cycle_count), 32'd2);
      chk("step2_off", 32'(pc_en), 32'd0);
      chk("step2_idle", 32'(running | halted), 32'd0);
      chk("step2_pc", pc, 32'h8);

      // 4-bit counter saturates
      do_reset();
      press(1'b0);
      cyc(25);
      chk("sat_cnt", 32'(cycle_count), 32'd15);
      chk("sat_run", 32'(pc_en), 32'd1);

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule
